// File: rtl/instruction_fetch_if.sv
// Program-memory read port shared between the fetch sequencer (master) and memory (slave).
// o_mem_read requests mem[o_mem_addr]; memory completes by raising i_mem_ready with i_mem_data
// in that same cycle. The master may drop o_mem_read without ever seeing ready (jump abort).
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  o_mem_read;
  logic [DATA_WIDTH-1:0] i_mem_data;
  logic                  i_mem_ready;

  modport master (
    output o_mem_addr,
    output o_mem_read,
    input  i_mem_data,
    input  i_mem_ready
  );

  modport slave (
    input  o_mem_addr,
    input  o_mem_read,
    output i_mem_data,
    output i_mem_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch sequencer: walks the PC through program memory and hands each word to the downstream
// instruction latch with a one-cycle enable pulse. Supports stall between fetches and jump/abort.
module instruction_fetch #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  instruction_fetch_if.master   mem,
  input  logic                  i_stall,
  input  logic                  i_jump,
  input  logic [ADDR_WIDTH-1:0] i_jump_addr,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic                  o_latch_enable,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_busy,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] pc, pc_next;
  logic [DATA_WIDTH-1:0] instr, instr_next;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      instr <= instr_next;
    end
  end

  // Jump wins in every state; in REQ/WAIT it also discards whatever memory returns that cycle.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instr;
    unique case (state)
      S_IDLE: begin
        if (i_jump) begin
          pc_next = i_jump_addr;
        end else if (!i_stall) begin
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (i_jump) begin
          pc_next    = i_jump_addr;
          state_next = S_IDLE;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_jump) begin
          pc_next    = i_jump_addr;
          state_next = S_IDLE;
        end else if (mem.i_mem_ready) begin
          instr_next = mem.i_mem_data;
          state_next = S_LATCH;
        end
      end
      S_LATCH: begin
        if (i_jump) begin
          pc_next    = i_jump_addr;
          state_next = S_IDLE;
        end else begin
          pc_next    = pc + ADDR_WIDTH'(1);
          state_next = i_stall ? S_IDLE : S_REQ;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign mem.o_mem_addr = pc;
  assign mem.o_mem_read = (state == S_REQ) || (state == S_WAIT);
  assign o_busy         = (state == S_REQ) || (state == S_WAIT);
  assign o_latch_enable = (state == S_LATCH);
  assign o_instr        = instr;
  assign o_pc           = pc;
  assign o_state        = state;

endmodule
